// File: rtl/vram_write_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vram_write_queue_pkg
// Brief    : Shared constants for the VRAM write queue: default VRAM address
//            width, default FIFO depth and drain FSM state encodings.
// Revision : 1.0 - initial release
// ============================================================================

`ifndef VRAM_ADDR_WIDTH
`define VRAM_ADDR_WIDTH 16
`endif

package vram_write_queue_pkg;

    localparam int VRAM_ADDR_WIDTH    = `VRAM_ADDR_WIDTH;
    localparam int FIFO_DEPTH_DEFAULT = 16;

    // Drain FSM encodings
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;

endpackage : vram_write_queue_pkg

`default_nettype wire

// File: rtl/sync_fifo_m.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_m
// Brief    : Generic synchronous circular-buffer FIFO with occupancy count,
//            full/empty flags and an "amend" port that rewrites the newest
//            entry in place. Head data is presented combinationally.
// Revision : 1.0 - initial release
// ============================================================================

module sync_fifo_m #(
    parameter int DEPTH = 16,   // power of two, minimum 2
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,        // synchronous, active-low
    input  logic                       push,
    input  logic                       pop,
    input  logic                       amend,      // overwrite entry at tail-1
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,      // entry at head
    output logic [WIDTH-1:0]           last_rdata, // entry at tail-1
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] last_ptr;

    assign last_ptr   = tail_q - PTR_ONE;
    assign rdata      = mem_q[head_q];
    assign last_rdata = mem_q[last_ptr];
    assign full       = (count_q == CNT_FULL);
    assign empty      = (count_q == '0);
    assign count      = count_q;

    // Next-state for storage, pointers and count; pointers wrap at DEPTH
    always_comb begin
        mem_d  = mem_q;
        head_d = head_q;
        tail_d = tail_q;
        if (amend) begin
            mem_d[last_ptr] = wdata;
        end
        if (push) begin
            mem_d[tail_q] = wdata;
            tail_d        = tail_q + PTR_ONE;
        end
        if (pop) begin
            head_d = head_q + PTR_ONE;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage; contents are meaningless while count says empty
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule : sync_fifo_m

`default_nettype wire

// File: rtl/vram_write_queue.sv
`default_nettype none
// ============================================================================
// Module   : vram_write_queue
// Brief    : Buffers CPU VRAM writes in a FIFO and drains them to the GPU
//            write port one per clock while vblank is open. Sticky overflow
//            flags dropped writes.
//            Build option: VRAM_WRITE_QUEUE_COALESCE_EN - a write to the same
//            address as the newest queued entry rewrites that entry's data.
// Revision : 1.0 - initial release
// ============================================================================

module vram_write_queue
    import vram_write_queue_pkg::*;
#(
    parameter int DEPTH  = FIFO_DEPTH_DEFAULT,
    parameter int ADDR_W = `VRAM_ADDR_WIDTH,
    parameter int DATA_W = 8
) (
    input  logic                       clk_12_5875,
    input  logic                       rst,          // synchronous, active-low
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       vblank,
    output logic [DATA_W-1:0]          gpu_data,
    output logic [ADDR_W-1:0]          gpu_address,
    output logic                       gpu_cs,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int ENT_W = ADDR_W + DATA_W;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [ENT_W-1:0]  head_ent;
    logic [ENT_W-1:0]  last_ent;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;

    logic              push_en;
    logic              pop_en;
    logic              amend_en;

    logic [0:0]        state_q, state_d;
    logic              cs_q, cs_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              overflow_q, overflow_d;

    sync_fifo_m #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_fifo (
        .clk        (clk_12_5875),
        .rst        (rst),
        .push       (push_en),
        .pop        (pop_en),
        .amend      (amend_en),
        .wdata      ({wr_addr, wr_data}),
        .rdata      (head_ent),
        .last_rdata (last_ent),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count)
    );

`ifdef VRAM_WRITE_QUEUE_COALESCE_EN
    // Same-address write folds into the newest entry unless that entry is
    // the one leaving the queue this cycle.
    assign amend_en = wr_en && !fifo_empty
                   && (last_ent[ENT_W-1:DATA_W] == wr_addr)
                   && !(pop_en && (fifo_count == CNT_ONE));
`else
    logic w_unused_last;
    assign w_unused_last = ^last_ent;
    assign amend_en      = 1'b0;
`endif

    // The pop qualifies already in the cycle vblank is first seen, so the
    // first cs follows the vblank sample by exactly one clock.
    assign pop_en  = vblank && !fifo_empty;
    assign push_en = wr_en && !amend_en && !fifo_full;

    // Drain FSM, output register and sticky overflow next-state
    always_comb begin
        state_d    = state_q;
        cs_d       = pop_en;
        data_d     = data_q;
        addr_d     = addr_q;
        overflow_d = overflow_q | (wr_en & ~amend_en & fifo_full);
        if (pop_en) begin
            addr_d = head_ent[ENT_W-1:DATA_W];
            data_d = head_ent[DATA_W-1:0];
        end
        unique case (state_q)
            ST_IDLE: begin
                if (vblank && !fifo_empty) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!vblank || (pop_en && !push_en && (fifo_count == CNT_ONE))) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Registered GPU port, FSM state and overflow flag
    always_ff @(posedge clk_12_5875) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cs_q       <= 1'b0;
            data_q     <= '0;
            addr_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cs_q       <= cs_d;
            data_q     <= data_d;
            addr_q     <= addr_d;
            overflow_q <= overflow_d;
        end
    end

    assign gpu_cs      = cs_q;
    assign gpu_data    = data_q;
    assign gpu_address = addr_q;
    assign overflow    = overflow_q;
    assign full        = fifo_full;
    assign empty       = fifo_empty;
    assign level       = fifo_count;

endmodule : vram_write_queue

`default_nettype wire

// File: doc/vram_write_queue.md
Name: vram_write_queue

Overview:
- Upstream feeder for the GPU's VRAM write port (data / address / cs).
- Buffers CPU-side VRAM writes that arrive at any time in a FIFO.
- Drains them to the GPU only while the vblank window is open, one write per clock.
- Keeps the GPU's read path free of contention during active display.

Parameters:
- DEPTH, 16, FIFO entries; power of two, minimum 2.
- ADDR_W, `VRAM_ADDR_WIDTH, VRAM address width.
- DATA_W, 8, VRAM data width.

Ports:
- clk_12_5875  input  1  GPU pixel clock; all logic on its rising edge.
- rst  input  1  synchronous, active-low reset (0 = reset).
- wr_en  input  1  CPU write strobe, one entry per cycle it is high.
- wr_addr  input  ADDR_W  CPU write address.
- wr_data  input  DATA_W  CPU write data.
- vblank  input  1  from GPU timing; 1 = VRAM writable.
- gpu_data  output  DATA_W  to GPU data.
- gpu_address  output  ADDR_W  to GPU address.
- gpu_cs  output  1  to GPU cs; one-cycle strobe per drained entry.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- overflow  output  1  sticky; set when a write is dropped.
- level  output  $clog2(DEPTH)+1  current entry count.

Behaviour:
- Reset (rst == 0 at a clock edge):
  - Pointers and count cleared; empty = 1, full = 0, overflow = 0, level = 0.
  - gpu_cs = 0, gpu_data = 0, gpu_address = 0; FSM returns to IDLE.
  - Reset mid-drain discards all queued entries. No cs is emitted on the reset cycle.
- Storage:
  - Circular buffer indexed by head and tail, each $clog2(DEPTH) bits; both wrap naturally at DEPTH.
  - count is kept separately, 0..DEPTH.
- Push:
  - Occurs when wr_en == 1 and full == 0, where full is the registered value at the start of the cycle.
  - wr_en with full == 1: the write is dropped and overflow is set, even if a pop happens in the same cycle. overflow clears only on reset.
- Pop / drain FSM:
  - IDLE -> DRAIN when vblank == 1 and empty == 0.
  - DRAIN: each cycle with vblank == 1 and empty == 0, pop the head and register it onto gpu_data / gpu_address with gpu_cs = 1 in the following cycle (latency 1).
  - DRAIN -> IDLE when vblank == 0 or the pop empties the queue.
  - gpu_cs is 0 in every cycle not preceded by a pop. gpu_data / gpu_address hold their last value when cs = 0.
- Same-cycle push and pop: count is unchanged; both pointers advance.
- Push into an empty queue: the entry becomes visible to the pop logic the next cycle. A write and its drain never share a cycle.
- vblank falling while entries remain: no pop in the cycle vblank is sampled 0. A cs already registered from the previous cycle still completes. Remaining entries wait for the next vblank.
- Ordering: strict FIFO; addresses reach the GPU in write order.

Optional Feature:
- Macro: VRAM_WRITE_QUEUE_COALESCE_EN.
- Defined: a push whose wr_addr equals the address of the newest queued entry (tail-1), while count >= 1, overwrites that entry's data instead of allocating.
  - count is unchanged and full is not checked.
  - Exception: if the newest entry is being popped in the same cycle, the write allocates normally.
- Undefined: every accepted write allocates a new entry.

Decomposition:
- Shared package / parameters file: VRAM_ADDR_WIDTH, FIFO depth default, FSM state encodings (IDLE = 0, DRAIN = 1).
- One natural sub-module: sync_fifo_m (generic synchronous FIFO with count, full/empty). vram_write_queue wraps it with the drain FSM, output register and overflow flag.

Test Plan:
- Reset: hold rst = 0 for 2 cycles with wr_en = 1 -> empty = 1, level = 0, gpu_cs = 0, overflow = 0 afterwards.
- Write 3 entries (0x010 / 0xAA, 0x011 / 0xBB, 0x012 / 0xCC) with vblank = 0, then raise vblank -> gpu_cs high for exactly 3 consecutive cycles starting 1 cycle after vblank is sampled, same order, then empty = 1.
- Fill 16, write a 17th (0x0FF / 0x55) -> full = 1, overflow = 1, level = 16; 0x0FF never appears on gpu_address.
- vblank high for 2 cycles with 5 queued -> exactly 2 cs pulses, level = 3; next vblank drains the remaining 3 in order.
- Same-cycle push and pop at level = 4 during vblank -> level stays 4, the pushed entry is emitted 4 pops later.
- COALESCE_EN: write 0x020 / 0x11 then 0x020 / 0x22 -> level = 1; the drain emits a single cs with 0x22. Without the macro: level = 2, two cs pulses.
